// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder: decodes command/address/data nibbles from the
// initiator and serves sequential-mode reads and writes from a local array.
module idli_sqi_mem_m #(
  parameter int DEPTH = 131072
) (
  input  logic       i_top_gck,
  input  logic       i_top_rst_n,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_en
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RD, WR, ERR
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            sck_q;
  logic            rise;
  logic            fall;
  logic [2:0]      cnt;
  logic [3:0]      cmd_hi;
  logic            is_rd;
  logic [3:0]      wr_hi;
  logic [AW-1:0]   addr;
  logic [7:0]      rd_byte;
  logic            we;
  logic [7:0]      mem [DEPTH];

  assign rise    = i_mem_sck & ~sck_q;
  assign fall    = ~i_mem_sck & sck_q;
  assign rd_byte = mem[addr];
  assign we      = ~i_mem_cs && state_q == WR
                   && rise && cnt == 3'd1;

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_mem_cs) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (rise && cnt == 3'd1) begin
            unique case ({cmd_hi, i_mem_sio})
              8'h03:   state_d = ADDR;
              8'h02:   state_d = ADDR;
              default: state_d = ERR;
            endcase
          end
        end
        ADDR: begin
          if (rise && cnt == 3'd5)
            state_d = is_rd ? DUMMY : WR;
        end
        DUMMY: begin
          if (rise && cnt == 3'd1) state_d = RD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      sck_q     <= 1'b0;
      cnt       <= 3'd0;
      cmd_hi    <= 4'h0;
      is_rd     <= 1'b0;
      wr_hi     <= 4'h0;
      addr      <= '0;
      o_mem_sio <= 4'h0;
      o_mem_en  <= 1'b0;
    end else begin
      sck_q <= i_mem_sck;
      if (i_mem_cs) begin
        cnt      <= 3'd0;
        o_mem_en <= 1'b0;
      end else begin
        unique case (state_q)
          CMD: begin
            if (rise) begin
              cmd_hi <= i_mem_sio;
              cnt    <= (cnt == 3'd1) ? 3'd0 : cnt + 3'd1;
              if (cnt == 3'd1)
                is_rd <= ({cmd_hi, i_mem_sio} == 8'h03);
            end
          end
          ADDR: begin
            // Shifting into an AW-bit register keeps only addr[AW-1:0].
            if (rise) begin
              addr <= {addr[AW-5:0], i_mem_sio};
              cnt  <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
            end
          end
          DUMMY: begin
            if (rise)
              cnt <= (cnt == 3'd1) ? 3'd0 : cnt + 3'd1;
          end
          RD: begin
            if (fall) begin
              o_mem_en <= 1'b1;
              if (cnt == 3'd0) begin
                o_mem_sio <= rd_byte[7:4];
                cnt       <= 3'd1;
              end else begin
                o_mem_sio <= rd_byte[3:0];
                cnt       <= 3'd0;
                addr      <= addr + AW'(1);
              end
            end
          end
          WR: begin
            if (rise) begin
              if (cnt == 3'd0) begin
                wr_hi <= i_mem_sio;
                cnt   <= 3'd1;
              end else begin
                cnt  <= 3'd0;
                addr <= addr + AW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Array has no reset: contents survive reset and CS.
  always_ff @(posedge i_top_gck) begin
    if (we) mem[addr] <= {wr_hi, i_mem_sio};
  end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: randomized SQI transactions checked
// against a byte-array memory model.
module tb_idli_sqi_mem_m;

  localparam int DEPTH = 131072;

  logic       gck = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       cs;
  logic [3:0] sio_i;
  logic [3:0] sio_o;
  logic       en;

  logic [7:0] model [DEPTH];
  logic [3:0] tx [$];
  logic [3:0] rx [$];
  logic       en_s [$];
  logic [7:0] wq [$];
  int n_cmp = 0;
  int n_bad = 0;

  idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
    .i_top_gck  (gck),
    .i_top_rst_n(rst_n),
    .i_mem_sck  (sck),
    .i_mem_cs   (cs),
    .i_mem_sio  (sio_i),
    .o_mem_sio  (sio_o),
    .o_mem_en   (en)
  );

  always #5 gck = ~gck;

  task automatic send();
    rx.delete();
    en_s.delete();
    foreach (tx[i]) begin
      sio_i = tx[i];
      @(negedge gck);
      rx.push_back(sio_o);
      en_s.push_back(en);
      sck = 1'b1;
      @(negedge gck);
      sck = 1'b0;
      @(negedge gck);
    end
  endtask

  task automatic xact_begin();
    if (cs) begin
      @(negedge gck);
      cs = 1'b0;
      @(negedge gck);
    end
  endtask

  task automatic xact_end(input bit pulse);
    cs = 1'b1;
    @(negedge gck);
    if (pulse) cs = 1'b0;
    @(negedge gck);
  endtask

  task automatic hdr(input logic [7:0] cmd, input int a);
    logic [23:0] a24;
    a24 = 24'(a);
    tx.delete();
    tx.push_back(cmd[7:4]);
    tx.push_back(cmd[3:0]);
    for (int i = 5; i >= 0; i--) tx.push_back(a24[4*i +: 4]);
  endtask

  task automatic do_write(input int a, input bit pulse);
    hdr(8'h02, a);
    foreach (wq[i]) begin
      tx.push_back(wq[i][7:4]);
      tx.push_back(wq[i][3:0]);
    end
    xact_begin();
    send();
    xact_end(pulse);
    foreach (wq[i]) model[(a + i) % DEPTH] = wq[i];
  endtask

  task automatic do_read(input string nm, input int a, input int n,
                         input bit chk_en);
    logic [7:0] exp_b;
    logic [7:0] got;
    hdr(8'h03, a);
    for (int i = 0; i < 2 + 2 * n; i++)
      tx.push_back(4'($urandom));
    xact_begin();
    send();
    xact_end(1'b0);
    if (chk_en) begin
      n_cmp++;
      if (en_s[9] !== 1'b0 || en_s[10] !== 1'b1) begin
        n_bad++;
        $display("FAIL %s en_timing got %b%b want 01", nm,
                 en_s[9], en_s[10]);
      end
    end
    for (int k = 0; k < n; k++) begin
      exp_b = model[(a + k) % DEPTH];
      got   = {rx[10 + 2 * k], rx[11 + 2 * k]};
      n_cmp++;
      if (got !== exp_b) begin
        n_bad++;
        $display("FAIL %s byte%0d addr %0h got %h want %h", nm, k,
                 (a + k) % DEPTH, got, exp_b);
      end
    end
  endtask

  task automatic check_array(input string nm);
    int d = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut.mem[i] !== model[i]) d++;
    n_cmp++;
    if (d != 0) begin
      n_bad++;
      $display("FAIL %s array diffs got %0d want 0", nm, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs    = 1'b1;
    sck   = 1'b0;
    sio_i = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      model[i]   = 8'($urandom);
      dut.mem[i] = model[i];
    end
    #1;
    n_cmp++;
    if (sio_o !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_sio got %h want 0", sio_o);
    end
    n_cmp++;
    if (en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_en got %b want 0", en);
    end
    repeat (2) @(negedge gck);
    rst_n = 1'b1;
    repeat (2) @(negedge gck);
  endtask

  task automatic test_write_read();
    wq = '{8'hA5, 8'h3C};
    do_write(32'h10, 1'b0);
    do_read("write_read", 32'h10, 2, 1'b1);
  endtask

  task automatic test_wrap();
    model[DEPTH-1]   = 8'h12;
    dut.mem[DEPTH-1] = 8'h12;
    model[0]         = 8'h34;
    dut.mem[0]       = 8'h34;
    do_read("wrap_rd", DEPTH - 1, 2, 1'b1);
    wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_write(DEPTH - 2, 1'b0);
    do_read("wrap_wr", DEPTH - 2, 3, 1'b1);
  endtask

  task automatic test_bad_cmd();
    tx = '{4'hF, 4'hF};
    repeat (12) tx.push_back(4'h5);
    xact_begin();
    send();
    xact_end(1'b0);
    foreach (en_s[i]) begin
      n_cmp++;
      if (en_s[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_cmd_en nib%0d got %b want 0", i, en_s[i]);
      end
    end
    check_array("bad_cmd");
    do_read("bad_cmd_next", 32'h5555, 2, 1'b1);
  endtask

  task automatic test_partial_write();
    hdr(8'h02, 32'h20);
    tx.push_back(4'h7);
    tx.push_back(4'h7);
    tx.push_back(4'h9);
    xact_begin();
    send();
    xact_end(1'b0);
    model[32'h20] = 8'h77;
    do_read("partial_wr", 32'h20, 2, 1'b1);
    check_array("partial_wr");
  endtask

  task automatic test_reset_mid_read();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    hdr(8'h03, a);
    repeat (5) tx.push_back(4'($urandom));
    xact_begin();
    send();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (en !== 1'b0 || sio_o !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_mid en/sio got %b/%h want 0/0", en, sio_o);
    end
    @(negedge gck);
    cs = 1'b1;
    repeat (2) @(negedge gck);
    rst_n = 1'b1;
    repeat (2) @(negedge gck);
    do_read("rst_mid_reread", a, 2, 1'b1);
  endtask

  task automatic test_collision();
    int a;
    logic [7:0] b;
    a = $urandom_range(0, DEPTH - 1);
    b = ~model[a];
    hdr(8'h02, a);
    tx.push_back(b[7:4]);
    xact_begin();
    send();
    sio_i = b[3:0];
    @(negedge gck);
    sck = 1'b1;
    cs  = 1'b1;
    @(negedge gck);
    sck = 1'b0;
    repeat (2) @(negedge gck);
    do_read("collision", a, 1, 1'b0);
  endtask

  task automatic test_random();
    int a;
    int n;
    for (int it = 0; it < 6; it++) begin
      a = (it == 5) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 5);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      do_write(a, 1'b0);
      do_read("rand_wr", a, n, 1'b1);
      do_read("rand_rd", $urandom_range(0, DEPTH - 1), 2, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    wq = '{8'($urandom), 8'($urandom)};
    do_write(a, 1'b1);
    do_read("b2b", a, 2, 1'b1);
    check_array("final");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_bad_cmd();
    test_partial_write();
    test_reset_mid_read();
    test_collision();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem_m.md
# idli_sqi_mem_m

Responder end of the idli SQI memory interface. It models one serial quad-I/O SRAM in sequential mode, is clocked by the core clock, and decodes the command, address and data nibbles driven by the core's SQI initiator. The bench instantiates two copies, one for low memory and one for high memory. It is synthesizable so FPGA bring-up can use it in place of external SRAM parts.

## Interface
- DEPTH, 131072, memory size in bytes; must be a power of two; AW = $clog2(DEPTH).
- i_top_gck  input  1  core clock; all logic on posedge.
- i_top_rst_n  input  1  reset i_top_rst_n, asynchronous, active-low.
- i_mem_sck  input  1  serial clock from initiator, synchronous to i_top_gck.
- i_mem_cs  input  1  chip select, active-low.
- i_mem_sio  input  4  nibble driven by initiator (slice_t).
- o_mem_sio  output  4  nibble driven to initiator (slice_t).
- o_mem_en  output  1  responder drives SIO when high.

## Operation
- Edge detect: sck_q is i_mem_sck registered each gck.
  - rise = i_mem_sck & ~sck_q.
  - fall = ~i_mem_sck & sck_q.
- Nibble order: high nibble first in each byte. The address is MSB nibble first.
- States: IDLE, CMD, ADDR, DUMMY, RD, WR, ERR. A 3-bit nibble counter is shared by all states.
- IDLE -> CMD when i_mem_cs is low. Any state -> IDLE when i_mem_cs is high; this has priority over everything else.
- CMD: sample 2 nibbles on rise.
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (write).
  - Any other value -> ERR.
- ADDR: sample 6 nibbles (24 bits) on rise. Only addr[AW-1:0] is kept.
  - Read -> DUMMY.
  - Write -> WR.
- DUMMY: sample and ignore 2 nibbles -> RD.
- RD: on each fall, drive the next nibble of mem[addr] on o_mem_sio, high nibble first. After the low nibble is driven, addr <= addr+1 mod DEPTH.
- o_mem_en goes high on the first fall in RD. It stays high until CS goes high or reset.
- WR: on each rise, capture a nibble. When the low nibble is captured, write the byte to mem[addr] and set addr <= addr+1 mod DEPTH.
- ERR: ignore all traffic. o_mem_en stays 0 and nothing is written. Exit only via CS high.
- Partial byte: a write byte with only its high nibble captured when CS rises is discarded. A partial read byte has no side effect.
- Memory contents are not affected by reset or CS. At power-up they are X; the bench preloads them by backdoor.

## Timing
- Reset values:
  - state = IDLE.
  - o_mem_sio = 4'h0.
  - o_mem_en = 0.
  - sck_q = 0.
  - addr = 0.
  - nibble counter = 0.
- Sampling: i_mem_sio is captured at the gck edge where rise is true.
- Driving: o_mem_sio and o_mem_en update at the gck edge where fall is true. They are valid before the next rise.
- Read latency: the first data nibble appears on the first falling SCK after the rising edge that samples the 2nd dummy nibble. That is 10 SCK rises after CS low.
- Write commit: the byte is in the array one gck after the rise that samples its low nibble. A read of that address in a later transaction returns the new value.
- CS high and rise at the same edge: CS wins; no sample, no write.
- CS high: state goes to IDLE and o_mem_en goes to 0 at that same gck edge, so both are visible the next cycle.
- A CS pulse of one gck returns the block to IDLE. The next CS low starts a fresh CMD.
- Asynchronous reset mid-transaction: outputs go to reset values immediately; the array is unchanged.
- Address wrap: the increment after DEPTH-1 goes to 0, in both RD and WR.

## Test plan
- Write then read: cmd 0x02, addr 0x000010, data 0xA5 0x3C, CS high; then cmd 0x03, addr 0x000010, 2 dummy nibbles, 4 data nibbles.
  - Required: read returns A,5,3,C.
  - Required: o_mem_en rises on the first fall after the dummy phase.
- Wrap: preload mem[DEPTH-1]=0x12 and mem[0]=0x34. Read 4 nibbles from addr DEPTH-1 -> 1,2,3,4.
- Bad command: send 0xFF followed by 12 nibbles of 0x5.
  - Required: o_mem_en stays 0.
  - Required: no array location changes.
  - Required: the next valid read works normally.
- Partial write: write 0x77 to addr 0x20, then only the nibble 0x9, then CS high.
  - Required: mem[0x20]=0x77.
  - Required: mem[0x21] keeps its old value.
- Reset mid-read: assert i_top_rst_n low during the RD phase.
  - Required: o_mem_en=0 and o_mem_sio=0 immediately.
  - Required: after release, a re-read returns the unchanged data.
- CS/SCK collision: deassert CS on the same gck as an SCK rise carrying the low nibble of a write -> that byte is not written.
